mem_access_sequencer: RTL

- Core-side initiator for the data-memory port of the z8 memory manager.
- Accepts load, store and block-copy requests from the execute stage over a valid/ready handshake.
- Sequences them into single-cycle mem_op/mem_addr/mem_wdata accesses and returns one response pulse per request.
- The memory port is unchanged: writes commit at posedge; read data returns combinationally in the same cycle as op/addr.

---
 rtl/mem_access_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// Data-memory access sequencer: turns load/store/block-copy requests into
// single-cycle memory-port accesses and returns one response pulse per request.
module mem_access_sequencer #(
  parameter int DATA_MEM_SIZE = 256,
  parameter int LEN_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [15:0]      req_addr,
  input  logic [15:0]      req_src,
  input  logic [LEN_W-1:0] req_len,
  input  logic [15:0]      req_wdata,
  output logic             rsp_valid,
  output logic [15:0]      rsp_data,
  output logic             rsp_err,
  output logic [1:0]       mem_op,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata
);

  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] KIND_LOAD  = 2'd0;
  localparam logic [1:0] KIND_STORE = 2'd1;
  localparam logic [1:0] KIND_COPY  = 2'd2;

  localparam logic [16:0] SIZE17 = 17'(DATA_MEM_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_COPY_RD, S_COPY_WR, S_RESP
  } state_t;

  state_t           state;
  logic [1:0]       kind_p0;
  logic [15:0]      addr_p0;
  logic [15:0]      src_p0;
  logic [LEN_W-1:0] len_p0;
  logic [15:0]      wdata_p0;
  logic [LEN_W-1:0] idx_p0;
  logic [15:0]      buf_p0;
  logic             err_p0;
  logic [LEN_W:0]   idx_next;

  // 17-bit sums so a window that wraps past 0xFFFF is rejected, not aliased low.
  function automatic logic out_of_range(input logic [1:0]       kind,
                                        input logic [15:0]      addr,
                                        input logic [15:0]      src,
                                        input logic [LEN_W-1:0] len);
    logic [16:0] src_last;
    logic [16:0] dst_last;
    src_last = {1'b0, src}  + 17'(len) - 17'd1;
    dst_last = {1'b0, addr} + 17'(len) - 17'd1;
    case (kind)
      KIND_LOAD, KIND_STORE: out_of_range = ({1'b0, addr} >= SIZE17);
      KIND_COPY:             out_of_range = (len != '0) &&
                                            ((src_last >= SIZE17) || (dst_last >= SIZE17));
      default:               out_of_range = 1'b1;
    endcase
  endfunction

  assign idx_next = {1'b0, idx_p0} + {{LEN_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      kind_p0  <= '0;
      addr_p0  <= '0;
      src_p0   <= '0;
      len_p0   <= '0;
      wdata_p0 <= '0;
      idx_p0   <= '0;
      buf_p0   <= '0;
      err_p0   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            kind_p0  <= req_kind;
            addr_p0  <= req_addr;
            src_p0   <= req_src;
            len_p0   <= req_len;
            wdata_p0 <= req_wdata;
            idx_p0   <= '0;
            buf_p0   <= '0;
            err_p0   <= 1'b0;
            if (out_of_range(req_kind, req_addr, req_src, req_len)) begin
              err_p0 <= 1'b1;
              state  <= S_RESP;
            end else begin
              case (req_kind)
                KIND_LOAD:  state <= S_LOAD;
                KIND_STORE: state <= S_STORE;
                default:    state <= (req_len == '0) ? S_RESP : S_COPY_RD;
              endcase
            end
          end
        end
        S_LOAD: begin
          buf_p0 <= mem_rdata;
          state  <= S_RESP;
        end
        S_STORE:   state <= S_RESP;
        S_COPY_RD: begin
          buf_p0 <= mem_rdata;
          state  <= S_COPY_WR;
        end
        S_COPY_WR: begin
          idx_p0 <= idx_next[LEN_W-1:0];
          state  <= (idx_next == {1'b0, len_p0}) ? S_RESP : S_COPY_RD;
        end
        S_RESP:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Port outputs are a pure decode of registered state: no req_* to mem_*/rsp_* path.
  always_comb begin
    mem_op    = MEM_IDLE;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_LOAD: begin
        mem_op   = MEM_READ;
        mem_addr = addr_p0;
      end
      S_STORE: begin
        mem_op    = MEM_WRITE;
        mem_addr  = addr_p0;
        mem_wdata = wdata_p0;
      end
      S_COPY_RD: begin
        mem_op   = MEM_READ;
        mem_addr = src_p0 + 16'(idx_p0);
      end
      S_COPY_WR: begin
        mem_op    = MEM_WRITE;
        mem_addr  = addr_p0 + 16'(idx_p0);
        mem_wdata = buf_p0;
      end
      default: ;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_err   = rsp_valid && err_p0;
  assign rsp_data  = (rsp_valid && (kind_p0 == KIND_LOAD) && !err_p0) ? buf_p0 : 16'h0000;

endmodule
